// File: rtl/rvvi_replay_list.sv
// rtl/rvvi_replay_list.sv - multi-port active list holding RVVI trace frames until host ack, with in-order replay
// Optional ack timeout replay is built when RVVI_AL_TIMEOUT_EN is defined.
module rvvi_replay_list #(
    parameter int DEPTH_LOG2        = 3,
    parameter int WIDTH             = 792,
    parameter int FRAME_COUNT_WIDTH = 16,
    parameter int ACK_PORTS         = 2,
    parameter int TIMEOUT_CYCLES    = 1024
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   DutValid,
    input  logic [WIDTH-1:0]                       DutData,
    output logic                                   InsertStall,
    input  logic [ACK_PORTS-1:0]                   HostAckValid,
    input  logic [ACK_PORTS*FRAME_COUNT_WIDTH-1:0] HostAckFrame,
    input  logic                                   RVVIStall,
    output logic                                   ReplayValid,
    output logic [WIDTH-1:0]                       ReplayData,
    output logic                                   Full,
    output logic                                   Empty,
    output logic [15:0]                            ReplayCount,
    output logic [15:0]                            DropCount
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;
    localparam int FCW   = FRAME_COUNT_WIDTH;

    typedef enum logic [1:0] {IDLE, REPLAY, WAIT} stateT;

    stateT                 state, stateNext;
    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH-1:0]      active, activeNext, matchAny;
    logic [PW-1:0]         headPtr, tailPtr, replayPtr, replayEnd;
    logic [PW-1:0]         headNext, tailNext, matchCount;
    logic [DEPTH_LOG2-1:0] firstOff, offs;
    logic                  found, outOfOrder, doInsert, doDrop;
    logic                  startReplay, replayAdvance, timeoutHit;

    assign doInsert    = DutValid && !Full;
    assign doDrop      = DutValid && Full;
    assign headNext    = headPtr + PW'(doInsert);
    assign InsertStall = (state != IDLE) || Full;
    assign ReplayData  = mem[replayPtr[DEPTH_LOG2-1:0]];

    // Full tag compare per port and entry; several ports hitting one entry count once.
    always_comb begin
        matchAny   = '0;
        matchCount = '0;
        for (int e = 0; e < DEPTH; e++) begin
            for (int i = 0; i < ACK_PORTS; i++) begin
                if (HostAckValid[i] && active[e] &&
                    mem[e][FCW-1:0] == HostAckFrame[i*FCW +: FCW]) begin
                    matchAny[e] = 1'b1;
                end
            end
            matchCount = matchCount + PW'(matchAny[e]);
        end
    end

    // Rotate by Tail and take the lowest set bit: Tail may skip several acked entries at once.
    always_comb begin
        found    = 1'b0;
        firstOff = '0;
        for (int j = DEPTH - 1; j >= 0; j--) begin
            if (active[tailPtr[DEPTH_LOG2-1:0] + DEPTH_LOG2'(j)]) begin
                found    = 1'b1;
                firstOff = DEPTH_LOG2'(j);
            end
        end
        tailNext = found ? tailPtr + {1'b0, firstOff} : headPtr;
    end

    // Offsets are taken from the post-jump tail so acks already cleared do not look like a gap.
    always_comb begin
        outOfOrder = 1'b0;
        offs       = '0;
        for (int e = 0; e < DEPTH; e++) begin
            offs = DEPTH_LOG2'(e) - tailNext[DEPTH_LOG2-1:0];
            if (matchAny[e] && ({1'b0, offs} >= matchCount)) begin
                outOfOrder = 1'b1;
            end
        end
    end

    always_comb begin
        activeNext = active & ~matchAny;
        if (doInsert) begin
            activeNext[headPtr[DEPTH_LOG2-1:0]] = 1'b1;
        end
    end

`ifdef RVVI_AL_TIMEOUT_EN
    logic [31:0] timeoutTimer;

    assign timeoutHit = (state != REPLAY) && !Empty &&
                        (timeoutTimer == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset || startReplay || (tailNext != tailPtr)) begin
            timeoutTimer <= '0;
        end else if ((state != REPLAY) && !Empty) begin
            timeoutTimer <= timeoutTimer + 32'd1;
        end
    end
`else
    assign timeoutHit = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        stateNext     = state;
        startReplay   = 1'b0;
        replayAdvance = 1'b0;
        ReplayValid   = 1'b0;
        case (state)
            IDLE: begin
                if (outOfOrder || timeoutHit) begin
                    stateNext   = REPLAY;
                    startReplay = 1'b1;
                end
            end
            REPLAY: begin
                if (!RVVIStall) begin
                    if (replayPtr == replayEnd) begin
                        stateNext = WAIT;
                    end else begin
                        replayAdvance = 1'b1;
                        ReplayValid   = active[replayPtr[DEPTH_LOG2-1:0]];
                    end
                end
            end
            WAIT: begin
                if (Empty) begin
                    stateNext = IDLE;
                end else if (timeoutHit) begin
                    stateNext   = REPLAY;
                    startReplay = 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            headPtr     <= '0;
            tailPtr     <= '0;
            replayPtr   <= '0;
            replayEnd   <= '0;
            active      <= '0;
            Full        <= 1'b0;
            Empty       <= 1'b1;
            ReplayCount <= '0;
            DropCount   <= '0;
        end else begin
            state   <= stateNext;
            headPtr <= headNext;
            tailPtr <= tailNext;
            active  <= activeNext;
            Full    <= (headNext - tailNext) == PW'(DEPTH);
            Empty   <= (headNext == tailNext);
            if (startReplay) begin
                replayPtr <= tailPtr;
                replayEnd <= headPtr;
                if (ReplayCount != 16'hFFFF) begin
                    ReplayCount <= ReplayCount + 16'd1;
                end
            end else if (replayAdvance) begin
                replayPtr <= replayPtr + PW'(1);
            end
            if (doDrop && DropCount != 16'hFFFF) begin
                DropCount <= DropCount + 16'd1;
            end
        end
    end

    // Payload storage carries no reset; validity lives in the active bits.
    always_ff @(posedge clk) begin
        if (doInsert) begin
            mem[headPtr[DEPTH_LOG2-1:0]] <= DutData;
        end
    end

endmodule

// File: tb/tb_rvvi_replay_list.sv
// tb/tb_rvvi_replay_list.sv - self-checking bench for rvvi_replay_list
module tb_rvvi_replay_list;

    localparam int WIDTH = 792;
    localparam int FCW   = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             DutValid;
    logic [WIDTH-1:0] DutData;
    logic             InsertStall;
    logic [1:0]       HostAckValid;
    logic [2*FCW-1:0] HostAckFrame;
    logic             RVVIStall;
    logic             ReplayValid;
    logic [WIDTH-1:0] ReplayData;
    logic             Full, Empty;
    logic [15:0]      ReplayCount, DropCount;

    int errors = 0;
    int checks = 0;
    int beats  = 0;
    logic [WIDTH-1:0] expQ [$];
    logic [WIDTH-1:0] frames [16];

    rvvi_replay_list #(
        .DEPTH_LOG2(3), .WIDTH(WIDTH), .FRAME_COUNT_WIDTH(FCW),
        .ACK_PORTS(2), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .reset(reset), .DutValid(DutValid), .DutData(DutData),
        .InsertStall(InsertStall), .HostAckValid(HostAckValid),
        .HostAckFrame(HostAckFrame), .RVVIStall(RVVIStall),
        .ReplayValid(ReplayValid), .ReplayData(ReplayData),
        .Full(Full), .Empty(Empty), .ReplayCount(ReplayCount), .DropCount(DropCount)
    );

    always #5 clk = ~clk;

    // Replay beats are matched against the scoreboard in the order they were predicted.
    always @(negedge clk) begin
        if (!reset && ReplayValid) begin
            logic [WIDTH-1:0] exp;
            beats++;
            checks++;
            assert (expQ.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_beat observed_tag=%0h expected=none", ReplayData[15:0]);
            end
            if (expQ.size() > 0) begin
                exp = expQ.pop_front();
                checks++;
                assert (ReplayData === exp) else begin
                    errors++;
                    $error("FAIL replay_beat observed=%0h expected=%0h", ReplayData[31:0], exp[31:0]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic insert(input logic [15:0] tag);
        logic [WIDTH-1:0] f;
        for (int b = 0; b < WIDTH / 8; b++) f[b*8 +: 8] = 8'($urandom);
        f[15:0] = tag;
        frames[tag[3:0]] = f;
        DutValid = 1'b1;
        DutData  = f;
        step();
        DutValid = 1'b0;
    endtask

    task automatic ack(input logic [15:0] t0, input logic v1, input logic [15:0] t1);
        HostAckValid = {v1, 1'b1};
        HostAckFrame = {t1, t0};
        step();
        HostAckValid = 2'b00;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && expQ.size() != 0; i++) step();
        step();
        step();
        check(name, expQ.size(), 0);
    endtask

    initial begin
        reset = 1'b1; DutValid = 1'b0; DutData = '0;
        HostAckValid = '0; HostAckFrame = '0; RVVIStall = 1'b0;
        step();
        step();
        reset = 1'b0;
        check("rst_empty", Empty, 1);
        check("rst_full", Full, 0);
        check("rst_stall", InsertStall, 0);
        check("rst_rvalid", ReplayValid, 0);
        check("rst_rcount", ReplayCount, 0);
        check("rst_dcount", DropCount, 0);

        // In-order acks, one per cycle
        for (int t = 0; t < 3; t++) insert(16'(t));
        check("t1_notempty", Empty, 0);
        for (int t = 0; t < 3; t++) ack(16'(t), 1'b0, 16'd0);
        step(); step(); step();
        check("t1_empty", Empty, 1);
        check("t1_rcount", ReplayCount, 0);
        check("t1_istall", InsertStall, 0);

        // Out-of-order ack replays the remaining entries in order
        for (int t = 0; t < 4; t++) insert(16'(t));
        expQ.push_back(frames[0]);
        expQ.push_back(frames[1]);
        expQ.push_back(frames[3]);
        ack(16'd2, 1'b0, 16'd0);
        check("t2_replay_stall", InsertStall, 1);
        drain("t2_drain");
        check("t2_wait_stall", InsertStall, 1);
        ack(16'd0, 1'b0, 16'd0);
        ack(16'd1, 1'b0, 16'd0);
        ack(16'd3, 1'b0, 16'd0);
        step(); step(); step();
        check("t2_empty", Empty, 1);
        check("t2_idle", InsertStall, 0);
        check("t2_rcount", ReplayCount, 1);

        // Full, drop, and release two cycles after the ack
        for (int t = 0; t < 8; t++) insert(16'(t));
        check("t3_full", Full, 1);
        check("t3_istall", InsertStall, 1);
        insert(16'd8);
        check("t3_dcount", DropCount, 1);
        check("t3_still_full", Full, 1);
        ack(16'd0, 1'b0, 16'd0);
        check("t3_full_ack1", Full, 1);
        step();
        check("t3_full_ack2", Full, 0);
        for (int t = 1; t < 8; t++) ack(16'(t), 1'b0, 16'd0);
        step(); step(); step();
        check("t3_empty", Empty, 1);
        check("t3_rcount", ReplayCount, 1);

        // Two ports ack the two oldest entries reversed: still in order
        for (int t = 0; t < 4; t++) insert(16'(t));
        ack(16'd1, 1'b1, 16'd0);
        ack(16'd10, 1'b0, 16'd0);
        check("t4_no_replay", InsertStall, 0);
        check("t4_rcount_a", ReplayCount, 1);
        // Entry 2 must still be active to be replayed here
        expQ.push_back(frames[2]);
        ack(16'd3, 1'b0, 16'd0);
        drain("t4_drain");
        check("t4_rcount_b", ReplayCount, 2);
        ack(16'd2, 1'b0, 16'd0);
        step(); step(); step();
        check("t4_empty", Empty, 1);
        check("t4_idle", InsertStall, 0);

        // Stalled replay interrupted by reset
        for (int t = 0; t < 6; t++) insert(16'(t));
        for (int t = 0; t < 5; t++) expQ.push_back(frames[t]);
        begin
            int b0;
            b0 = beats;
            ack(16'd5, 1'b0, 16'd0);
            for (int i = 0; i < 4; i++) begin
                RVVIStall = i[0];
                #2;
                if (i[0]) check("t5_stall_hold", ReplayValid, 0);
                step();
            end
            RVVIStall = 1'b0;
            reset = 1'b1;
            step();
            check("t5_rvalid", ReplayValid, 0);
            reset = 1'b0;
            check("t5_beats", beats - b0, 2);
        end
        expQ.delete();
        check("t5_empty", Empty, 1);
        check("t5_idle", InsertStall, 0);
        check("t5_rcount", ReplayCount, 0);

`ifdef RVVI_AL_TIMEOUT_EN
        begin
            int hit;
            hit = 0;
            insert(16'd5);
            expQ.push_back(frames[5]);
            for (int i = 1; i <= 40 && hit == 0; i++) begin
                step();
                if (ReplayValid) hit = i;
            end
            check("t6_timeout_cycle", hit, 16);
            drain("t6_drain");
            check("t6_rcount", ReplayCount, 1);
            ack(16'd5, 1'b0, 16'd0);
            step(); step(); step();
            check("t6_empty", Empty, 1);
            check("t6_idle", InsertStall, 0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
